vx_smem_lane_responder: RTL

// - Responder end of the per-lane dcache core request/response protocol driven by the LSU: accepts
//   per-lane rd/wr requests, serves them from a banked on-chip word store, returns read data by tag.
// - Sits where the dcache would (local scratchpad / unit-test stand-in).
// - Stores: write and produce no response. Loads: one response beat per accepted request cycle.

---
 rtl/vx_smem_lane_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vx_smem_lane_responder.sv
// vx_smem_lane_responder: per-lane request/response responder backed by a banked
// on-chip word store. Stores update the array silently. Every request cycle that
// accepts at least one read returns one response beat, in order, with a fixed
// two-cycle latency when the response queue is empty and drained.
// Optional build macro SMEM_BCAST_EN: same-bank, same-row reads share one array
// read instead of being serialised by the bank-conflict rule.
`default_nettype none

module vx_smem_lane_responder #(
  parameter int NUM_LANES  = 4,
  parameter int BANK_WORDS = 256,
  parameter int TAG_W      = 8,
  parameter int RSPQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_LANES-1:0]       req_valid,
  input  logic [NUM_LANES-1:0]       req_rw,
  input  logic [NUM_LANES*30-1:0]    req_addr,
  input  logic [NUM_LANES*4-1:0]     req_byteen,
  input  logic [NUM_LANES*32-1:0]    req_data,
  input  logic [NUM_LANES*TAG_W-1:0] req_tag,
  output logic [NUM_LANES-1:0]       req_ready,
  output logic [NUM_LANES-1:0]       rsp_valid,
  output logic [NUM_LANES*32-1:0]    rsp_data,
  output logic [TAG_W-1:0]           rsp_tag,
  input  logic                       rsp_ready
);

  localparam int BANK_BITS = $clog2(NUM_LANES);
  localparam int ROW_BITS  = $clog2(BANK_WORDS);
  localparam int PTR_W     = $clog2(RSPQ_DEPTH);
  localparam int CNT_W     = $clog2(RSPQ_DEPTH + 1);

  logic [BANK_BITS-1:0]    lane_bank [NUM_LANES];
  logic [ROW_BITS-1:0]     lane_row  [NUM_LANES];
  logic [31:0]             mem [NUM_LANES][BANK_WORDS];

  logic                    stage_valid;
  logic [NUM_LANES-1:0]    stage_mask;
  logic [TAG_W-1:0]        stage_tag;
  logic [NUM_LANES*32-1:0] stage_data;

  logic [NUM_LANES-1:0]    q_mask [RSPQ_DEPTH];
  logic [TAG_W-1:0]        q_tag  [RSPQ_DEPTH];
  logic [NUM_LANES*32-1:0] q_data [RSPQ_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        q_count;

  logic [CNT_W:0]          occ;
  logic                    credit_ok;
  logic [NUM_LANES-1:0]    lane_ready;
  logic [NUM_LANES-1:0]    rd_fire;
  logic [NUM_LANES-1:0]    wr_fire;
  logic [TAG_W-1:0]        rd_tag;
  logic                    push;
  logic                    pop;
  logic                    unused_addr_bits;

  // Upper address bits above bank+row alias onto the same word.
  assign unused_addr_bits = ^req_addr;

  // Split each lane's word address into bank select and row within the bank.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_bank[i] = req_addr[i*30 +: BANK_BITS];
      lane_row[i]  = req_addr[i*30 + BANK_BITS +: ROW_BITS];
    end
  end

  // Reads need a response slot: count the staged beat as well as queued ones.
  always_comb begin
    occ       = {1'b0, q_count} + {{CNT_W{1'b0}}, stage_valid};
    credit_ok = (occ < (CNT_W+1)'(RSPQ_DEPTH));
  end

  // Per-lane accept: lowest lane wins a bank; reads additionally need credit.
  always_comb begin
    logic stall;
    lane_ready = '0;
    stall      = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      stall = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (req_valid[j] && (lane_bank[j] == lane_bank[i])) begin
`ifdef SMEM_BCAST_EN
          if (req_rw[j] || req_rw[i] || (lane_row[j] != lane_row[i])) stall = 1'b1;
`else
          stall = 1'b1;
`endif
        end
      end
      lane_ready[i] = reset_n && !stall && (req_rw[i] || credit_ok);
    end
  end

  // Fired lanes, and the beat tag taken from the lowest accepted read lane.
  always_comb begin
    rd_fire = req_valid & lane_ready & ~req_rw;
    wr_fire = req_valid & lane_ready & req_rw;
    rd_tag  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (rd_fire[i]) rd_tag = req_tag[i*TAG_W +: TAG_W];
    end
  end

  // Word store: byte-enabled writes and the one-cycle read into the stage data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (wr_fire[i]) begin
        for (int b = 0; b < 4; b++) begin
          if (req_byteen[i*4 + b])
            mem[lane_bank[i]][lane_row[i]][b*8 +: 8] <= req_data[i*32 + b*8 +: 8];
        end
      end
      if (rd_fire[i]) stage_data[i*32 +: 32] <= mem[lane_bank[i]][lane_row[i]];
    end
  end

  assign push = stage_valid;
  assign pop  = (q_count != '0) && rsp_ready;

  // Stage flag and queue bookkeeping; reset discards everything outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_mask  <= '0;
      stage_tag   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
    end else begin
      stage_valid <= |rd_fire;
      stage_mask  <= rd_fire;
      if (|rd_fire) stage_tag <= rd_tag;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase
    end
  end

  // Queue payload storage; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      q_mask[wr_ptr] <= stage_mask;
      q_tag[wr_ptr]  <= stage_tag;
      q_data[wr_ptr] <= stage_data;
    end
  end

  // Head of the queue drives the response beat.
  always_comb begin
    rsp_valid = (q_count != '0) ? q_mask[rd_ptr] : '0;
    rsp_data  = q_data[rd_ptr];
    rsp_tag   = q_tag[rd_ptr];
    req_ready = lane_ready;
  end

  a_req_valid_known: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown(req_valid));

endmodule

`default_nettype wire
